// File: rtl/exec_result_stage_pkg.sv
// Shared CPU definitions: ALU opcode encodings, result-stage FSM states and
// helpers for classifying divide opcodes and taking operand magnitudes.
package exec_result_stage_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] OP_OR   = 4'b0000;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_XOR  = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_NOTA = 4'b1000;
   localparam logic [3:0] OP_DIVS = 4'b1001;
   localparam logic [3:0] OP_DIVU = 4'b1010;
   localparam logic [3:0] OP_MODS = 4'b1011;
   localparam logic [3:0] OP_MODU = 4'b1100;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DIV  = 1'b1
   } state_e;

   // Captured at accept so the final sign fix-up needs no operand history.
   typedef struct packed {
      logic want_rem;
      logic neg_q;
      logic neg_r;
   } div_ctl_t;

   function automatic logic is_div_op(input logic [3:0] op);
      return op inside {OP_DIVS, OP_DIVU, OP_MODS, OP_MODU};
   endfunction

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/exec_result_stage_udiv_iter.sv
// Unsigned restoring divider, one quotient bit per step; quotient/remainder
// show the post-step values so the caller can register them on the final step.
module udiv_iter
   import exec_result_stage_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            done
);

   localparam int CW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [XLEN:0]   shifted;
   logic [XLEN:0]   trial;
   logic            fits;
   logic [XLEN-1:0] quo_step;
   logic [XLEN-1:0] rem_step;

   always_comb begin
      shifted  = {rem_q, quo_q[XLEN-1]};
      trial    = shifted - {1'b0, dvs_q};
      fits     = !trial[XLEN];
      quo_step = {quo_q[XLEN-2:0], fits};
      // Partial remainder stays below the divisor, so the top bit is always clear.
      rem_step = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];

      quotient  = quo_step;
      remainder = rem_step;
      done      = (cnt_q == CW'(DIV_ITER - 1));

      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      if (start) begin
         quo_d = dividend;
         rem_d = '0;
         dvs_d = divisor;
         cnt_d = '0;
      end else if (step) begin
         quo_d = quo_step;
         rem_d = rem_step;
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/exec_result_stage.sv
// EX result register: simple ops in 1 cycle, divides via iterative divider in
// DIV_ITER+1 cycles; stall_in holds everything, flush kills EX and aborts a divide.
module exec_result_stage
   import exec_result_stage_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            valid_in,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      opcode,
   input  logic            skip,
   input  logic [XLEN-1:0] alu_y,
   input  logic            alu_bga,
   input  logic            alu_bea,
   input  logic            stall_in,
   input  logic            flush,
   output logic            busy,
   output logic            valid_out,
   output logic [XLEN-1:0] result,
   output logic            bga_q,
   output logic            bea_q
);

   state_e          state_q, state_d;
   div_ctl_t        ctl_q, ctl_d;
   logic            pend_bga_q, pend_bga_d;
   logic            pend_bea_q, pend_bea_d;
   logic            valid_out_q, valid_out_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            bga_d, bea_d;

   logic            is_div, div_signed, want_rem, b_zero;
   logic            accept, div_step, div_done;
   logic [XLEN-1:0] dividend_mag, divisor_mag;
   logic [XLEN-1:0] div_quo, div_rem, quo_fix, rem_fix, div_res;

   always_comb begin
      is_div       = !skip && is_div_op(opcode);
      div_signed   = (opcode == OP_DIVS) || (opcode == OP_MODS);
      want_rem     = (opcode == OP_MODS) || (opcode == OP_MODU);
      b_zero       = (b == '0);
      accept       = (state_q == ST_IDLE) && valid_in && is_div && !b_zero && !flush && !stall_in;
      div_step     = (state_q == ST_DIV) && !stall_in && !flush;
      dividend_mag = mag(a, div_signed);
      divisor_mag  = mag(b, div_signed);
   end

   udiv_iter #(
      .DIV_ITER (DIV_ITER)
   ) u_div (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (accept),
      .step      (div_step),
      .dividend  (dividend_mag),
      .divisor   (divisor_mag),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   // Quotient sign follows the operand-sign xor, remainder follows the dividend.
   always_comb begin
      quo_fix = ctl_q.neg_q ? (~div_quo + 1'b1) : div_quo;
      rem_fix = ctl_q.neg_r ? (~div_rem + 1'b1) : div_rem;
      div_res = ctl_q.want_rem ? rem_fix : quo_fix;
   end

   always_comb begin
      if (!reset_n || flush) begin
         busy = 1'b0;
      end else if (stall_in) begin
         busy = 1'b1;
      end else if (state_q == ST_DIV) begin
         busy = !div_done;
      end else begin
         busy = valid_in && is_div && !b_zero;
      end
   end

   always_comb begin
      state_d     = state_q;
      ctl_d       = ctl_q;
      pend_bga_d  = pend_bga_q;
      pend_bea_d  = pend_bea_q;
      valid_out_d = valid_out_q;
      result_d    = result_q;
      bga_d       = bga_q;
      bea_d       = bea_q;

      if (flush) begin
         valid_out_d = 1'b0;
         state_d     = ST_IDLE;
      end else if (!stall_in) begin
         valid_out_d = 1'b0;
         if (state_q == ST_IDLE) begin
            if (accept) begin
               state_d        = ST_DIV;
               ctl_d.want_rem = want_rem;
               ctl_d.neg_q    = div_signed && (a[XLEN-1] ^ b[XLEN-1]);
               ctl_d.neg_r    = div_signed && a[XLEN-1];
               pend_bga_d     = alu_bga;
               pend_bea_d     = alu_bea;
            end else if (valid_in) begin
               valid_out_d = 1'b1;
               bga_d       = alu_bga;
               bea_d       = alu_bea;
               // Divide by zero resolves here: quotient all-ones, remainder = a.
               if (is_div) begin
                  result_d = want_rem ? a : '1;
               end else begin
                  result_d = alu_y;
               end
            end
         end else if (div_done) begin
            state_d     = ST_IDLE;
            valid_out_d = 1'b1;
            result_d    = div_res;
            bga_d       = pend_bga_q;
            bea_d       = pend_bea_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         ctl_q       <= '0;
         pend_bga_q  <= 1'b0;
         pend_bea_q  <= 1'b0;
         valid_out_q <= 1'b0;
         result_q    <= '0;
         bga_q       <= 1'b0;
         bea_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctl_q       <= ctl_d;
         pend_bga_q  <= pend_bga_d;
         pend_bea_q  <= pend_bea_d;
         valid_out_q <= valid_out_d;
         result_q    <= result_d;
         bga_q       <= bga_d;
         bea_q       <= bea_d;
      end
   end

   assign valid_out = valid_out_q;
   assign result    = result_q;

endmodule

// File: tb/tb_exec_result_stage.sv
// Bench for exec_result_stage: vector table plus stall, flush and reset sequences,
// with results checked through an in-order scoreboard.
module tb_exec_result_stage;
   import exec_result_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid_in;
   logic [31:0] a, b, alu_y;
   logic [3:0]  opcode;
   logic        skip, alu_bga, alu_bea, stall_in, flush;
   logic        busy, valid_out, bga_q, bea_q;
   logic [31:0] result;

   exec_result_stage #(.DIV_ITER(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .valid_in  (valid_in),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .skip      (skip),
      .alu_y     (alu_y),
      .alu_bga   (alu_bga),
      .alu_bea   (alu_bea),
      .stall_in  (stall_in),
      .flush     (flush),
      .busy      (busy),
      .valid_out (valid_out),
      .result    (result),
      .bga_q     (bga_q),
      .bea_q     (bea_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic        skp;
      logic [31:0] va, vb, vy;
      logic        fbga, fbea;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic        bga;
      logic        bea;
   } exp_t;

   vec_t tbl[15];
   exp_t exp_q[$];
   exp_t mon_e;
   int   compared   = 0;
   int   mismatched = 0;

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // A result is consumed when it is presented while downstream is not stalled.
   always @(negedge clk) begin
      if (reset_n && valid_out && !stall_in) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_valid: result 0x%08h, expected no result outstanding", result);
         end else begin
            mon_e = exp_q.pop_front();
            check32("sb_result", result, mon_e.res);
            check32("sb_flags", {30'd0, bga_q, bea_q}, {30'd0, mon_e.bga, mon_e.bea});
         end
      end
   end

   task automatic idle_inputs();
      valid_in = 1'b0; stall_in = 1'b0; flush = 1'b0; skip = 1'b0;
      opcode = OP_OR; a = '0; b = '0; alu_y = '0; alu_bga = 1'b0; alu_bea = 1'b0;
   endtask

   task automatic garbage();
      valid_in = 1'b1; stall_in = 1'b0; flush = 1'b0;
      skip   = 1'($urandom);
      opcode = 4'($urandom_range(0, 12));
      a = $urandom; b = $urandom; alu_y = $urandom;
      alu_bga = 1'($urandom); alu_bea = 1'($urandom);
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vy, input logic fbga, input logic fbea);
      @(posedge clk); #1;
      idle_inputs();
      valid_in = 1'b1; opcode = op; a = va; b = vb; alu_y = vy;
      alu_bga = fbga; alu_bea = fbea;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int  lat;
      int  busy_cnt;
      bit  seen;
      issue(v.op, v.va, v.vb, v.vy, v.fbga, v.fbea);
      skip = v.skp;
      exp_q.push_back(exp_t'{v.exp, v.fbga, v.fbea});
      lat = 0; busy_cnt = 0; seen = 1'b0;
      @(negedge clk);
      if (busy) busy_cnt++;
      for (int c = 1; c <= 60 && !seen; c++) begin
         @(posedge clk); #1;
         if (c < v.lat) garbage(); else idle_inputs();
         @(negedge clk);
         if (valid_out) begin
            seen = 1'b1;
            lat  = c;
         end else if (busy) begin
            busy_cnt++;
         end
      end
      check32({nm, "_latency"}, 32'(lat), 32'(v.lat));
      check32({nm, "_busy_cycles"}, 32'(busy_cnt), 32'((v.lat > 1) ? v.lat - 1 : 0));
      if (!seen) exp_q.delete();
   endtask

   initial begin : main
      int lat;
      int n_valid;
      int n_busy;

      tbl[0]  = '{OP_ADD,  1'b0, 32'd3,        32'd4,        32'h7,        1'b0, 1'b0, 32'h7,        1};
      tbl[1]  = '{OP_XOR,  1'b0, 32'hA5A50F0F, 32'h00000F0F, 32'hA5A50000, 1'b1, 1'b0, 32'hA5A50000, 1};
      tbl[2]  = '{OP_DIVS, 1'b1, 32'h11,       32'h55,       32'h55,       1'b0, 1'b1, 32'h55,       1};
      tbl[3]  = '{OP_DIVS, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hDEADBEEF, 1'b1, 1'b0, 32'hFFFFFFFD, 33};
      tbl[4]  = '{OP_MODS, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hDEADBEEF, 1'b0, 1'b1, 32'hFFFFFFFF, 33};
      tbl[5]  = '{OP_DIVU, 1'b0, 32'h12345678, 32'd0,        32'hDEADBEEF, 1'b0, 1'b1, 32'hFFFFFFFF, 1};
      tbl[6]  = '{OP_MODU, 1'b0, 32'h12345678, 32'd0,        32'hDEADBEEF, 1'b1, 1'b1, 32'h12345678, 1};
      tbl[7]  = '{OP_DIVS, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h80000000, 33};
      tbl[8]  = '{OP_MODS, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000, 33};
      tbl[9]  = '{OP_DIVS, 1'b0, 32'd7,        32'hFFFFFFFE, 32'hDEADBEEF, 1'b1, 1'b1, 32'hFFFFFFFD, 33};
      tbl[10] = '{OP_MODS, 1'b0, 32'd7,        32'hFFFFFFFE, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000001, 33};
      tbl[11] = '{OP_DIVU, 1'b0, 32'hFFFFFFFF, 32'd3,        32'hDEADBEEF, 1'b1, 1'b0, 32'h55555555, 33};
      tbl[12] = '{OP_MODU, 1'b0, 32'd100,      32'd7,        32'hDEADBEEF, 1'b0, 1'b1, 32'h00000002, 33};
      tbl[13] = '{OP_MODS, 1'b0, 32'hFFFFFFF9, 32'd0,        32'hDEADBEEF, 1'b1, 1'b0, 32'hFFFFFFF9, 1};
      tbl[14] = '{OP_DIVS, 1'b0, 32'h80000000, 32'd2,        32'hDEADBEEF, 1'b0, 1'b0, 32'hC0000000, 33};

      idle_inputs();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check32("reset_valid_out", 32'(valid_out), 32'd0);
      check32("reset_result", result, 32'd0);
      check32("reset_flags", {30'd0, bga_q, bea_q}, 32'd0);
      check32("reset_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Stall during the last iteration, then stall again while the result is presented.
      issue(OP_DIVU, 32'd1000, 32'd10, 32'hDEADBEEF, 1'b1, 1'b1);
      exp_q.push_back(exp_t'{32'd100, 1'b1, 1'b1});
      lat = 0;
      for (int c = 1; c <= 50; c++) begin
         @(posedge clk); #1;
         if (c <= 37) garbage(); else idle_inputs();
         stall_in = ((c >= 32) && (c <= 34)) || ((c >= 36) && (c <= 37));
         @(negedge clk);
         if (c == 33) check32("stall_busy", 32'(busy), 32'd1);
         if (c == 34) check32("stall_no_valid", 32'(valid_out), 32'd0);
         if (c == 35) check32("stall_last_busy", 32'(busy), 32'd0);
         if (c == 37) check32("stall_hold_result", result, 32'd100);
         if (c == 37) check32("stall_hold_valid", 32'(valid_out), 32'd1);
         if (valid_out && lat == 0) lat = c;
      end
      check32("stall_latency", 32'(lat), 32'd36);

      // Flush beats valid_in: a divide offered with flush is never accepted.
      issue(OP_DIVU, 32'd5, 32'd1, 32'hDEADBEEF, 1'b0, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      check32("flush_accept_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check32("flush_accept_idle_busy", 32'(busy), 32'd0);
      check32("flush_accept_valid", 32'(valid_out), 32'd0);
      check32("flush_result_hold", result, 32'd100);

      // Flush at iteration 10 of a running divide.
      issue(OP_DIVU, 32'hFFFF0000, 32'd3, 32'hDEADBEEF, 1'b0, 1'b0);
      n_valid = 0; n_busy = 0;
      for (int c = 1; c <= 50; c++) begin
         @(posedge clk); #1;
         idle_inputs();
         flush = (c == 11);
         @(negedge clk);
         if (c == 5) check32("div_busy_mid", 32'(busy), 32'd1);
         if (c == 11) check32("flush_div_busy", 32'(busy), 32'd0);
         if (c > 11 && busy) n_busy++;
         if (valid_out) n_valid++;
      end
      check32("flush_div_no_valid", 32'(n_valid), 32'd0);
      check32("flush_div_idle_busy", 32'(n_busy), 32'd0);
      run_vec('{OP_ADD, 1'b0, 32'd1, 32'd2, 32'h33, 1'b1, 1'b1, 32'h33, 1}, "post_flush_add");

      // Asynchronous reset in the middle of a divide.
      issue(OP_DIVU, 32'd500, 32'd3, 32'hDEADBEEF, 1'b0, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         idle_inputs();
      end
      #2 reset_n = 1'b0;
      #1;
      check32("arst_valid_out", 32'(valid_out), 32'd0);
      check32("arst_result", result, 32'd0);
      check32("arst_flags", {30'd0, bga_q, bea_q}, 32'd0);
      check32("arst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      n_valid = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (valid_out) n_valid++;
      end
      check32("arst_no_result", 32'(n_valid), 32'd0);
      run_vec('{OP_DIVU, 1'b0, 32'd100, 32'd7, 32'hDEADBEEF, 1'b0, 1'b1, 32'd14, 33}, "post_reset_divu");

      repeat (3) @(negedge clk);
      check32("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/exec_result_stage.md
EXEC_RESULT_STAGE -- requirements
Module: exec_result_stage

Interface
REQ-001 Ports (name  direction  width  meaning), in this order:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  EX-stage instruction present.
- a, b  in  32 each  EX operands, same values driven to the ALU.
- opcode  in  4  EX ALU opcode.
- skip  in  1  ALU pass-through of b.
- alu_y  in  32  ALU result.
- alu_bga, alu_bea  in  1 each  ALU compare flags.
- stall_in  in  1  downstream stage cannot accept.
- flush  in  1  kill the EX instruction.
- busy  out  1  upstream holds the EX instruction and operands.
- valid_out  out  1  registered result valid.
- result  out  32  registered result.
- bga_q, bea_q  out  1 each  registered flags.
REQ-002 Parameter: DIV_ITER (default 32) = divider iterations, one quotient bit per cycle.

Function
REQ-003 Divide opcodes (when skip=0): 4'b1001 DIVS (signed quotient), 4'b1010 DIVU (unsigned quotient), 4'b1011 MODS (signed remainder), 4'b1100 MODU (unsigned remainder); all other opcodes and any skip=1 are simple ops.
REQ-004 Simple op (valid_in, no stall_in, no flush): next edge registers result=alu_y, bga_q=alu_bga, bea_q=alu_bea, valid_out=1; latency 1 cycle; busy=0.
REQ-005 FSM states: IDLE and DIV; an instruction is accepted only in IDLE.
REQ-006 IDLE -> DIV on valid_in & divide opcode & b!=0 & !flush & !stall_in. At that edge: operand magnitudes, sign flags and op are loaded and count=0. busy=1 combinationally in the accept cycle.
REQ-007 DIV behaviour: one restoring-division iteration per cycle. In the cycle where count==DIV_ITER-1, busy=0. That edge registers the result, sets valid_out=1 and returns the FSM to IDLE. Accept-to-valid latency = DIV_ITER+1 cycles.
REQ-008 DIV ignores valid_in, a, b and opcode; the held instruction is never re-accepted.
REQ-009 Sign rules: the quotient is negated when the operand signs differ; the remainder takes the sign of a. The case -2^31 / -1 gives quotient 0x80000000 and remainder 0.
REQ-010 Divide by zero (b==0) completes as a simple op with latency 1. Quotient ops give 0xFFFFFFFF; remainder ops give a.
REQ-011 bga_q and bea_q for divide ops are registered from alu_bga/alu_bea, captured at accept.
REQ-012 stall_in=1 behaviour: output registers hold, busy=1, and a DIV in its last iteration holds at count DIV_ITER-1.
REQ-013 flush=1 behaviour: the next edge clears valid_out, aborts any DIV (FSM -> IDLE) and drives busy=0 in that cycle. flush has priority over stall_in and valid_in.
REQ-014 No valid_in (and no stall_in): valid_out=0 next edge; result and flags hold their last values.

Reset
REQ-015 reset_n low asynchronously forces state=IDLE, count=0, valid_out=0, result=0, bga_q=0, bea_q=0 and busy=0.
REQ-016 Reset asserted mid-DIV discards the division; no result is produced after release.

Structure
REQ-017 The shared CPU package holds the 4-bit opcode constants (OP_OR..OP_NOTA plus OP_DIVS, OP_DIVU, OP_MODS, OP_MODU on 1001-1100) and the FSM state encoding.
REQ-018 One sub-module, udiv_iter: an unsigned iterative restoring divider with ports start, dividend, divisor, quotient, remainder, done. Sign handling stays in exec_result_stage.

Verification
REQ-019 Simple op: ADD, alu_y=0x00000007, valid_in=1 -> next cycle valid_out=1, result=0x00000007, busy=0 throughout.
REQ-020 DIVS, a=-7 (0xFFFFFFF9), b=2 -> busy high 32 cycles; valid_out 33 cycles after accept; result=0xFFFFFFFD. MODS on the same operands -> 0xFFFFFFFF.
REQ-021 DIVU, a=0x12345678, b=0 -> 1-cycle latency, result=0xFFFFFFFF. MODU on the same operands -> 0x12345678.
REQ-022 DIVS, a=0x80000000, b=0xFFFFFFFF -> result=0x80000000. MODS on the same operands -> 0.
REQ-023 DIVU with stall_in=1 during the last iteration for 3 cycles -> result and valid_out delayed 3 cycles, value correct, no re-accept. Second test: flush at iteration 10 -> no valid_out, busy=0, FSM IDLE.
REQ-024 reset_n pulsed low mid-DIV -> all outputs 0 immediately. After release, a DIVU 100/7 -> result=14.
